// File: rtl/mem_access_unit.sv
// mem_access_unit: sequential MEM-stage load/store unit driving a req/ack memory port
// Ports:
//   clk, reset            clock and synchronous active-low reset
//   req_valid/req_ready   access handshake from the MEM stage (ready only when idle)
//   addr, write_data      byte address and LSB-justified store data
//   mem_size              000 B, 001 H, 010 W, 100 BU, 101 HU
//   mem_read, mem_write   operation select (exactly one must be set)
//   resp_valid            one-cycle completion pulse with read_data and fault
//   busy                  pipeline stall while an access is in flight
//   mem_*/byte_enable     word-aligned external memory request, held until mem_ack
module mem_access_unit #(
   parameter int ADDR_W = 32,
   parameter int TIMEOUT = 16,
   parameter bit MISALIGN_SPLIT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       write_data,
   input  logic [2:0]        mem_size,
   input  logic              mem_read,
   input  logic              mem_write,
   output logic              resp_valid,
   output logic [31:0]       read_data,
   output logic              fault,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_data_out,
   input  logic [31:0]       mem_data_in,
   output logic              mem_read_en,
   output logic              mem_write_en,
   output logic [3:0]        byte_enable,
   input  logic              mem_ack
);
   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
   state_t      state_q;
   logic [1:0]  off_q;
   logic [2:0]  size_q;
   logic        split_q;
   logic [31:0] hi_data_q;
   logic [3:0]  hi_be_q;
   logic [31:0] lo_q;
   logic [31:0] cnt_q;
   logic [2:0]  nbytes;
   logic [7:0]  mask8;
   logic [63:0] wide;
   logic        split;
   logic        illegal;
   logic        timed_out;
   logic [31:0] raw;
   logic [31:0] ld;
   assign req_ready = state_q == IDLE;
   assign busy = state_q != IDLE;
   always_comb begin
      nbytes = mem_size[1:0] == 2'b00 ? 3'd1 : mem_size[1:0] == 2'b01 ? 3'd2 : 3'd4;
      split = ({1'b0, addr[1:0]} + nbytes) > 3'd4;
      mask8 = {4'h0, nbytes == 3'd1 ? 4'h1 : nbytes == 3'd2 ? 4'h3 : 4'hF} << addr[1:0];
      wide = {32'h0, write_data} << {addr[1:0], 3'b000};
      illegal = (mem_read == mem_write) || mem_size == 3'b011 || mem_size[2:1] == 2'b11;
      // ack wins over timeout when both land on the same cycle
      timed_out = (TIMEOUT != 0) && !mem_ack && cnt_q == 32'(TIMEOUT - 1);
      // a non-split access lives entirely in the current word, so the upper half is don't-care
      raw = 32'({state_q == ACC1 ? mem_data_in : 32'h0, state_q == ACC1 ? lo_q : mem_data_in} >> {off_q, 3'b000});
      ld = size_q == 3'b000 ? {{24{raw[7]}}, raw[7:0]} :
           size_q == 3'b001 ? {{16{raw[15]}}, raw[15:0]} :
           size_q == 3'b100 ? {24'h0, raw[7:0]} :
           size_q == 3'b101 ? {16'h0, raw[15:0]} : raw;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         off_q <= '0;
         size_q <= '0;
         split_q <= 1'b0;
         hi_data_q <= '0;
         hi_be_q <= '0;
         lo_q <= '0;
         cnt_q <= '0;
         resp_valid <= 1'b0;
         read_data <= '0;
         fault <= 1'b0;
         mem_addr <= '0;
         mem_data_out <= '0;
         mem_read_en <= 1'b0;
         mem_write_en <= 1'b0;
         byte_enable <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state_q)
            IDLE: if (req_valid) begin
               off_q <= addr[1:0];
               size_q <= mem_size;
               split_q <= split;
               hi_data_q <= wide[63:32];
               hi_be_q <= mask8[7:4];
               cnt_q <= '0;
               if (illegal || (split && !MISALIGN_SPLIT)) begin
                  state_q <= RESP;
                  resp_valid <= 1'b1;
                  fault <= 1'b1;
                  read_data <= '0;
               end else begin
                  state_q <= ACC0;
                  mem_addr <= {addr[ADDR_W-1:2], 2'b00};
                  byte_enable <= mask8[3:0];
                  mem_data_out <= wide[31:0];
                  mem_read_en <= mem_read;
                  mem_write_en <= mem_write;
               end
            end
            ACC0, ACC1: if (mem_ack && state_q == ACC0 && split_q) begin
               state_q <= ACC1;
               lo_q <= mem_data_in;
               cnt_q <= '0;
               mem_addr <= mem_addr + ADDR_W'(4);
               byte_enable <= hi_be_q;
               mem_data_out <= hi_data_q;
            end else if (mem_ack || timed_out) begin
               state_q <= RESP;
               resp_valid <= 1'b1;
               fault <= timed_out;
               read_data <= (mem_read_en && !timed_out) ? ld : 32'h0;
               mem_addr <= '0;
               mem_data_out <= '0;
               mem_read_en <= 1'b0;
               mem_write_en <= 1'b0;
               byte_enable <= '0;
            end else begin
               cnt_q <= cnt_q + 32'd1;
            end
            RESP: begin
               state_q <= IDLE;
               fault <= 1'b0;
               read_data <= '0;
            end
         endcase
      end
   end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Sequential successor to the combinational MEM-stage memory interface. It accepts one load/store per handshake from the MEM stage and drives a request/acknowledge external memory port with arbitrary wait states. It splits misaligned accesses into two aligned word transactions, with an optional fault mode instead. It supports signed and unsigned sub-word loads and a per-access timeout, and stalls the pipeline while busy.

Parameters:
ADDR_W, 32, address width; byte-addressed, word = 4 bytes.
TIMEOUT, 16, max cycles mem_req waits for mem_ack before fault; 0 disables timeout.
MISALIGN_SPLIT, 1, 1 = split misaligned access into two words; 0 = misaligned access faults with no memory traffic.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
req_valid  in  1  MEM stage presents access
req_ready  out  1  high only in IDLE
addr  in  ADDR_W  byte address
write_data  in  32  store data, LSB-justified
mem_size  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (bit2 = zero-extend)
mem_read  in  1  load
mem_write  in  1  store
resp_valid  out  1  one-cycle completion pulse
read_data  out  32  extended load result, valid with resp_valid, else 0
fault  out  1  valid with resp_valid: misaligned (split off), timeout, illegal op
busy  out  1  stall request to pipeline: state != IDLE
mem_addr  out  ADDR_W  word-aligned address (addr[1:0] = 00)
mem_data_out  out  32  lane-shifted store data
mem_data_in  in  32  read word, valid when mem_ack = 1
mem_read_en  out  1  read request, held until mem_ack
mem_write_en  out  1  write request, held until mem_ack
byte_enable  out  4  active lanes for the current word
mem_ack  in  1  memory completes current word this cycle

Behaviour:
- Reset (reset == 0 at an edge): state=IDLE. Outputs are resp_valid=0, read_data=0, fault=0, busy=0, mem_read_en=0, mem_write_en=0, byte_enable=0, mem_addr=0, mem_data_out=0, and the timeout counter is 0. Reset mid-transaction drops the request at that edge; no response is issued.
- States: IDLE, ACC0, ACC1, RESP.
- IDLE: when req_valid && req_ready, latch addr, size, op and the 64-bit write value {32'b0, write_data} << 8*addr[1:0].
  - nbytes is 1, 2 or 4; split = addr[1:0] + nbytes > 4.
  - Illegal op (mem_read && mem_write, neither set, or size 011/11x) -> RESP with fault=1.
  - split && !MISALIGN_SPLIT -> RESP with fault=1.
  - Otherwise -> ACC0.
- ACC0: mem_addr = {addr[ADDR_W-1:2], 2'b00}.
  - byte_enable = ((1<<nbytes)-1) << addr[1:0], low 4 bits.
  - mem_data_out = shifted value [31:0].
  - On mem_ack, capture mem_data_in into the low word. If split -> ACC1, else -> RESP.
- ACC1: mem_addr = previous + 4, wrapping modulo 2^ADDR_W.
  - byte_enable = high 4 bits of the 8-bit shifted mask.
  - mem_data_out = shifted value [63:32].
  - On mem_ack, capture into the high word and go -> RESP.
- Timeout: the counter clears on entry to ACC0/ACC1 and increments each cycle without ack. If it reaches TIMEOUT, go -> RESP with fault=1, drop the request the same edge, and discard partial read data. A partial split store is not rolled back.
- RESP: resp_valid=1 for exactly one cycle, then -> IDLE.
  - For loads without fault: raw = {hi, lo} >> 8*addr[1:0]. read_data = raw sign- or zero-extended from bit 7 or 15 per size; W passes through.
  - Stores, or any fault: read_data=0.
- mem_read_en/mem_write_en are high only in ACC0/ACC1 and depend only on registered state, with no combinational input-to-output path.
- Latency, aligned, ack on first request cycle: accept at edge T, request during T+1, resp_valid during T+2. Each wait cycle adds 1; a split access adds the ACC1 duration.
- mem_ack outside ACC0/ACC1 is ignored. req_valid while busy is ignored (req_ready=0).

Test Plan:
- Aligned LW at 0x100, mem_data_in=0xDEADBEEF, ack immediate -> mem_addr=0x100, be=1111; resp_valid 2 cycles after accept, read_data=0xDEADBEEF, fault=0.
- LB at 0x103, then LBU at 0x103, word 0x80FF0000, ack after 3 waits -> be=1000, read_data=0xFFFFFF80 then 0x00000080, each latency 5.
- Split SW 0xAABBCCDD at 0x102 (MISALIGN_SPLIT=1) -> word 0x100 be=1100 data 0xCCDD0000; word 0x104 be=0011 data 0x0000AABB; resp fault=0.
- Split LH at 0x0FF with words 0x34xxxxxx, 0xxxxxxx12 (x = don't care) -> read_data=0x00001234; with MISALIGN_SPLIT=0 -> no mem_read_en, resp fault=1.
- TIMEOUT=4, no ack -> mem_read_en high exactly 4 cycles, then resp_valid with fault=1, read_data=0.
- reset low while in ACC1 -> next edge all outputs 0, req_ready=1, no resp_valid.
